// File: rtl/data_mem_responder.sv
// Data-memory target for the core MEM stage: word-addressed RAM plus an MMIO window
// holding an LED register and a compare timer with sticky match and interrupt.
module data_mem_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [3:0]  MMIO_TAG  = 4'h1
) (
    input  logic        CLOCK,
    input  logic        RST,
    input  logic        ena_rd,
    input  logic        ena_wr,
    input  logic [31:0] addr,
    input  logic [31:0] dataram_wr,
    output logic [31:0] dataram_rd,
    output logic [31:0] leds,
    output logic        irq,
    output logic        bus_err
);

    localparam int unsigned IdxW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    localparam logic [7:0] OffLeds  = 8'h00;
    localparam logic [7:0] OffCount = 8'h04;
    localparam logic [7:0] OffCmp   = 8'h08;
    localparam logic [7:0] OffCtrl  = 8'h0C;
    localparam logic [7:0] OffErr   = 8'h10;

    logic [31:0] ram_q [RAM_WORDS];

    logic [31:0] leds_q, leds_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        match_q, match_d;
    logic        irq_en_q, irq_en_d;
    logic        ar_q, ar_d;
    logic        irq_q, irq_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    logic            sel_ram, sel_mmio, aligned, legal, illegal;
    logic            ram_we, mmio_we, hit;
    logic [IdxW-1:0] ram_idx;
    logic [7:0]      offset;

    assign ram_idx  = addr[IdxW+1:2];
    assign offset   = addr[7:0];
    assign aligned  = (addr[1:0] == 2'b00);
    assign sel_ram  = (addr[31:28] == 4'h0) && ({6'd0, addr[27:2]} < RAM_WORDS);
    assign sel_mmio = (addr[31:28] == MMIO_TAG);
    assign legal    = aligned && (sel_ram || sel_mmio);
    assign illegal  = (ena_rd || ena_wr) && !legal;
    assign ram_we   = ena_wr && legal && sel_ram;
    assign mmio_we  = ena_wr && legal && !sel_ram && sel_mmio;
    assign hit      = en_q && (cnt_q == cmp_q);

    // RAM is never cleared; the reset term only drops a write that coincides with reset.
    always_ff @(posedge CLOCK or posedge RST) begin
        if (!RST && ram_we) begin
            ram_q[ram_idx] <= dataram_wr;
        end
    end

    always_comb begin
        dataram_rd = 32'd0;
        if (ena_rd && legal) begin
            if (sel_ram) begin
                dataram_rd = ram_q[ram_idx];
            end else begin
                case (offset)
                    OffLeds:  dataram_rd = leds_q;
                    OffCount: dataram_rd = cnt_q;
                    OffCmp:   dataram_rd = cmp_q;
                    OffCtrl:  dataram_rd = {28'd0, ar_q, irq_en_q, match_q, en_q};
                    OffErr:   dataram_rd = err_cnt_q;
                    default:  dataram_rd = 32'd0;
                endcase
            end
        end
    end

    always_comb begin
        leds_d    = leds_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        en_d      = en_q;
        match_d   = match_q;
        irq_en_d  = irq_en_q;
        ar_d      = ar_q;
        bus_err_d = illegal;
        err_cnt_d = err_cnt_q;

        if (en_q) begin
            cnt_d = (hit && ar_q) ? 32'd0 : cnt_q + 32'd1;
        end

        if (mmio_we) begin
            case (offset)
                OffLeds:  leds_d = dataram_wr;
                OffCount: cnt_d  = dataram_wr;
                OffCmp:   cmp_d  = dataram_wr;
                OffCtrl: begin
                    en_d     = dataram_wr[0];
                    irq_en_d = dataram_wr[2];
                    ar_d     = dataram_wr[3];
                    if (dataram_wr[1]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A hardware match wins over a same-cycle write-1 clear.
        if (hit) begin
            match_d = 1'b1;
        end
        irq_d = match_d && irq_en_d;

        if (illegal && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            leds_q    <= 32'd0;
            cnt_q     <= 32'd0;
            cmp_q     <= 32'hFFFF_FFFF;
            en_q      <= 1'b0;
            match_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            ar_q      <= 1'b0;
            irq_q     <= 1'b0;
            bus_err_q <= 1'b0;
            err_cnt_q <= 32'd0;
        end else begin
            leds_q    <= leds_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            en_q      <= en_d;
            match_q   <= match_d;
            irq_en_q  <= irq_en_d;
            ar_q      <= ar_d;
            irq_q     <= irq_d;
            bus_err_q <= bus_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign leds    = leds_q;
    assign irq     = irq_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios plus random traffic
// against a transaction-level model of RAM, MMIO registers and timer.
module tb_data_mem_responder;

    localparam int unsigned RamWords = 1024;

    logic        CLOCK = 1'b0;
    logic        RST;
    logic        ena_rd, ena_wr;
    logic [31:0] addr, dataram_wr;
    logic [31:0] dataram_rd, leds;
    logic        irq, bus_err;

    data_mem_responder #(
        .RAM_WORDS(RamWords),
        .MMIO_TAG (4'h1)
    ) dut (
        .CLOCK     (CLOCK),
        .RST       (RST),
        .ena_rd    (ena_rd),
        .ena_wr    (ena_wr),
        .addr      (addr),
        .dataram_wr(dataram_wr),
        .dataram_rd(dataram_rd),
        .leds      (leds),
        .irq       (irq),
        .bus_err   (bus_err)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] leds;
        logic        irq;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [31:0] ram_m [16];
    logic [31:0] m_leds, m_cnt, m_cmp, m_errc;
    logic        m_en, m_match, m_irqen, m_ar, m_irq, m_berr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_leds = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_errc = 0;
        m_en = 0; m_match = 0; m_irqen = 0; m_ar = 0; m_irq = 0; m_berr = 0;
    endtask

    // 0 = illegal, 1 = RAM, 2 = MMIO
    function automatic int classify(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 0;
        if (a[31:28] == 4'h0) return ((a >> 2) < RamWords) ? 1 : 0;
        if (a[31:28] == 4'h1) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        if (!rd) return 32'd0;
        case (classify(a))
            1: return ram_m[a[5:2]];
            2: begin
                case (a[7:0])
                    8'h00:   return m_leds;
                    8'h04:   return m_cnt;
                    8'h08:   return m_cmp;
                    8'h0C:   return {28'd0, m_ar, m_irqen, m_match, m_en};
                    8'h10:   return m_errc;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
        int          k = classify(a);
        logic        ill = (rd || wr) && (k == 0);
        logic        matched = m_en && (m_cnt == m_cmp);
        logic [31:0] new_cnt = m_cnt;
        logic        new_match = m_match;
        if (m_en) new_cnt = (matched && m_ar) ? 32'd0 : m_cnt + 1;
        if (wr && k == 1) ram_m[a[5:2]] = d;
        if (wr && k == 2) begin
            if (a[7:0] == 8'h00) m_leds = d;
            if (a[7:0] == 8'h04) new_cnt = d;
            if (a[7:0] == 8'h08) m_cmp = d;
            if (a[7:0] == 8'h0C) begin
                m_en = d[0]; m_irqen = d[2]; m_ar = d[3];
                if (d[1]) new_match = 0;
            end
        end
        if (matched) new_match = 1;
        m_cnt   = new_cnt;
        m_match = new_match;
        m_irq   = m_match && m_irqen;
        m_berr  = ill;
        if (ill && m_errc != 32'hFFFF_FFFF) m_errc = m_errc + 1;
    endtask

    // One bus cycle; called just after a rising edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
        exp_t e;
        ena_rd = rd; ena_wr = wr; addr = a; dataram_wr = d;
        e.rd = model_read(rd, a);
        e.leds = m_leds;
        e.irq = m_irq;
        e.berr = m_berr;
        exp_q.push_back(e);
        model_step(rd, wr, a, d);
        @(posedge CLOCK);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] offs [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'hFC};
        case ($urandom_range(7, 0))
            0, 1, 2: return {26'd0, 4'($urandom_range(15, 0)), 2'b00};
            3, 4, 5: return 32'h1000_0000 | offs[$urandom_range(6, 0)];
            6:       return {26'd0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 1))};
            default: return {4'($urandom_range(15, 2)), 28'($urandom)};
        endcase
    endfunction

    always @(negedge CLOCK) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("dataram_rd", dataram_rd, mon_e.rd);
            chk("leds", leds, mon_e.leds);
            chk("irq", {31'd0, irq}, {31'd0, mon_e.irq});
            chk("bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        RST = 1'b1; ena_rd = 0; ena_wr = 0; addr = 0; dataram_wr = 0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1 RST = 1'b0;
        chk("reset_leds", leds, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
        chk("idle_rd_zero", dataram_rd, 32'd0);

        // Reset asserted mid-cycle while an LED write is pending
        cyc(0, 1, 32'h1000_0000, 32'h55);
        ena_wr = 1; addr = 32'h1000_0000; dataram_wr = 32'hAA;
        #2 RST = 1'b1;
        #1;
        chk("rst_async_leds", leds, 32'd0);
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        chk("rst_async_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge CLOCK);
        #1 ena_wr = 0;
        #1 RST = 1'b0;
        model_reset();
        chk("rst_write_lost", leds, 32'd0);
        @(posedge CLOCK);
        #1;

        // Illegal accesses: misaligned, unmapped region, RAM just past the end
        cyc(1, 0, 32'h0000_0002, 0);
        cyc(0, 1, 32'h4000_0000, 32'h1234_5678);
        cyc(1, 0, RamWords * 4, 0);
        cyc(1, 0, 32'h1000_0010, 0);
        cyc(0, 0, 0, 0);

        // RAM write/read, same-cycle read-modify
        cyc(0, 1, 32'h10, 32'hDEAD_BEEF);
        cyc(1, 0, 32'h10, 0);
        cyc(1, 1, 32'h10, 32'h1);
        cyc(1, 0, 32'h10, 0);

        // Timer compare with interrupt, then clear
        cyc(0, 1, 32'h1000_0008, 5);
        cyc(0, 1, 32'h1000_0004, 0);
        cyc(0, 1, 32'h1000_000C, 32'h5);
        repeat (7) cyc(1, 0, 32'h1000_0004, 0);
        cyc(1, 0, 32'h1000_000C, 0);
        cyc(0, 1, 32'h1000_000C, 32'h7);
        repeat (3) cyc(1, 0, 32'h1000_0004, 0);

        // Auto-reload
        cyc(0, 1, 32'h1000_000C, 32'h2);
        cyc(0, 1, 32'h1000_0008, 3);
        cyc(0, 1, 32'h1000_0004, 0);
        cyc(0, 1, 32'h1000_000C, 32'h9);
        repeat (9) cyc(1, 0, 32'h1000_0004, 0);
        cyc(1, 0, 32'h1000_000C, 0);

        // Counter wrap, then match on the following edge
        cyc(0, 1, 32'h1000_000C, 32'h2);
        cyc(0, 1, 32'h1000_0004, 32'hFFFF_FFFF);
        cyc(0, 1, 32'h1000_0008, 0);
        cyc(0, 1, 32'h1000_000C, 32'h5);
        repeat (3) cyc(1, 0, 32'h1000_0004, 0);
        cyc(1, 0, 32'h1000_000C, 0);

        for (int w = 0; w < 16; w++) cyc(0, 1, 32'(w * 4), $urandom);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a = rand_addr();
            logic [31:0] d = $urandom;
            if (a == 32'h1000_0008 && $urandom_range(1, 0) == 1) d = d & 32'h3F;
            cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), a, d);
        end

        ena_rd = 0; ena_wr = 0;
        @(negedge CLOCK);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Target side of the core's data-memory interface. Services the pipeline's MEM-stage read/write strobes against a word-addressed data RAM and a small memory-mapped peripheral window. The window holds an LED register and a 32-bit timer with compare, sticky match flag and interrupt. The block sits between the core's MEM-stage outputs and board I/O, and returns read data in the same cycle so the core's MEM/WB register captures it on the next edge.

Parameters:
RAM_WORDS, 1024, number of 32-bit data RAM words (power of 2, at most 2^26)
MMIO_TAG, 4'h1, value of addr[31:28] selecting the peripheral window

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
RST  input  1  reset, active-high, asynchronous
ena_rd  input  1  read strobe from core MEM stage
ena_wr  input  1  write strobe from core MEM stage
addr  input  32  byte address (core ALU result, MEM stage)
dataram_wr  input  32  store data from core
dataram_rd  output  32  load data to core, combinational
leds  output  32  LED register contents
irq  output  1  timer interrupt level
bus_err  output  1  registered one-cycle pulse on an illegal access

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset asserted forces leds=0, timer count=0, cmp=32'hFFFF_FFFF, ctrl=0, irq=0, bus_err=0, err_cnt=0. RAM contents are not reset.
- Reset mid-operation: any write in the same cycle is discarded; registers hold their reset values until the first edge after deassertion.
- Access is word-only. Address decode:
  - RAM: addr[31:28]==0, index = addr[31:2], legal when index < RAM_WORDS.
  - MMIO: addr[31:28]==MMIO_TAG, offset = addr[7:0].
  - Anything else: illegal.
- Misaligned access (addr[1:0]!=0) is illegal.
- Illegal access (ena_rd or ena_wr high, address illegal):
  - write ignored; dataram_rd=0
  - bus_err=1 on the following cycle only
  - err_cnt increments, saturating at 32'hFFFF_FFFF
- Read:
  - dataram_rd is valid combinationally in the same cycle as ena_rd, zero latency.
  - dataram_rd=0 whenever ena_rd is low.
  - A read returns the pre-edge value. Reading a location written in the same cycle returns the old data.
- Write: takes effect on the rising edge in which ena_wr is high.
- ena_rd and ena_wr both high: the write is performed and the read returns the old value.
- MMIO map (offset, access, meaning):
  - 0x00 RW: leds
  - 0x04 RW: timer count
  - 0x08 RW: cmp
  - 0x0C RW: ctrl
    - bit0 en
    - bit1 match, sticky; write 1 clears, write 0 leaves it unchanged
    - bit2 irq_en
    - bit3 auto_reload
    - bits[31:4] read 0, writes ignored
  - 0x10 RO: err_cnt; writes ignored, not an error
  - Other offsets in the window: read 0, writes ignored, not an error.
- Timer, each cycle with en=1:
  - count <= count+1, wrapping 32'hFFFF_FFFF -> 0.
  - When count==cmp at the edge:
    - match <= 1
    - if auto_reload: count <= 0 instead of incrementing
  - en=0: count holds; no new match is detected.
- Priorities in a single cycle:
  - A software write to count overrides both increment and reload.
  - Setting match by hardware overrides a write-1 clear in the same cycle.
- irq = match & irq_en, registered, updated on the same edge as the ctrl bits.

Test Plan:
1. RST pulse mid-cycle while ena_wr=1 to 0x1000_0000 with data 0xAA -> leds=0 immediately, write lost, irq=0, bus_err=0.
2. Write 0xDEADBEEF to 0x0000_0010, next cycle ena_rd at 0x10 -> dataram_rd=0xDEADBEEF. Same-cycle ena_rd+ena_wr of 0x1 to 0x10 -> returns 0xDEADBEEF; a later read returns 0x1.
3. Write cmp=5, count=0, ctrl=0x5 -> match/irq rise 6 edges after the ctrl write. Read ctrl=0x7. Write ctrl=0x7 -> match clears and irq=0 next cycle; count continues 6, 7, ...
4. auto_reload: cmp=3, ctrl=0x9 -> count sequence 1, 2, 3, 0, 1, ...; match set at the reload edge.
5. ena_rd at 0x0000_0002, then ena_wr at 0x4000_0000, then ena_rd at byte address RAM_WORDS*4 -> dataram_rd=0 each time, three bus_err pulses, err_cnt reads 3, RAM unchanged.
6. count=0xFFFF_FFFF, cmp=0, en=1 -> wraps to 0, then match sets on the next edge.
